// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES-256 decryption datapath.
// Includes the GF(2^8) multiply used by the inverse-column helper.
package aes_dec_pkg;

    localparam int AES_STATE_W  = 128;
    localparam int AES_COL_W    = 32;
    localparam int AES_NUM_COLS = 4;
    localparam int AES_COL_IDX_W = $clog2(AES_NUM_COLS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant m (covers 09, 0b, 0d, 0e).
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? a  : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
               (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_columns_seq_helper.sv
// Combinational InvMixColumns on a single 32-bit column.
// Byte 0 of the column is rc[31:24].
module MixColumnHelper
    import aes_dec_pkg::*;
(
    input  logic [AES_COL_W-1:0] rc,
    output logic [AES_COL_W-1:0] mcl
);

    logic [7:0] a [4];
    logic [7:0] r [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            a[k] = rc[AES_COL_W-1-8*k -: 8];
        end
        for (int k = 0; k < 4; k++) begin
            r[k] = gf_mul(a[k], 4'he) ^
                   gf_mul(a[(k+1)%4], 4'hb) ^
                   gf_mul(a[(k+2)%4], 4'hd) ^
                   gf_mul(a[(k+3)%4], 4'h9);
        end
    end

    assign mcl = {r[0], r[1], r[2], r[3]};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// InvMixColumns sequencer: streams the four state columns through
// COLS_PER_CYCLE shared helpers and hands the result downstream.
module inv_mix_columns_seq
    import aes_dec_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int NUM_STEPS = AES_NUM_COLS / COLS_PER_CYCLE;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    state_e                 state_q, state_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [AES_STATE_W-1:0] work_q, work_d, work_run;
    logic [AES_COL_W-1:0]   cols  [AES_NUM_COLS];
    logic [AES_COL_W-1:0]   h_in  [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0]   h_out [COLS_PER_CYCLE];
    logic                   accept;

    for (genvar c = 0; c < AES_NUM_COLS; c++) begin : g_cols
        assign cols[c] = work_q[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W];
    end

    // Instance i always serves columns congruent to i mod COLS_PER_CYCLE.
    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_helper
        logic [AES_COL_IDX_W-1:0] cidx;
        assign cidx = AES_COL_IDX_W'(int'(step_q) * COLS_PER_CYCLE + i);
        assign h_in[i] = cols[cidx];
        MixColumnHelper u_helper (
            .rc  (h_in[i]),
            .mcl (h_out[i])
        );
    end

    always_comb begin
        work_run = work_q;
        for (int c = 0; c < AES_NUM_COLS; c++) begin
            if (int'(step_q) == c / COLS_PER_CYCLE) begin
                work_run[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W] =
                    h_out[c % COLS_PER_CYCLE];
            end
        end
    end

    assign in_ready = rst_n & ~flush &
                      ((state_q == ST_IDLE) |
                       ((state_q == ST_HOLD) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign out_state = work_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        work_d  = work_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    work_d  = in_state;
                    step_d  = '0;
                    state_d = in_bypass ? ST_HOLD : ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = work_run;
                if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                    step_d  = '0;
                    state_d = ST_HOLD;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        work_d  = in_state;
                        step_d  = '0;
                        state_d = in_bypass ? ST_HOLD : ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            step_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            work_q  <= work_d;
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq at 1, 2 and 4 columns per cycle.
// Expected states are the published AES InvMixColumns column vectors.
module tb_inv_mix_columns_seq;

    localparam logic [127:0] V_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] B_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] W_IN  = 128'hd5d5d7d6_4d7ebdf8_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] W_OUT = 128'hd4d4d4d5_2d26314c_d4d4d4d5_2d26314c;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_ready;

    logic         in_ready,  out_valid,  busy;
    logic [127:0] out_state;
    logic         in_ready2, out_valid2, busy2;
    logic [127:0] out_state2;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] out_state4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_bypass(in_bypass),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy)
    );

    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_state(in_state), .in_bypass(in_bypass),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_state(out_state2), .busy(busy2)
    );

    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_state(in_state), .in_bypass(in_bypass),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_state(out_state4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_state = '0; in_bypass = 1'b0; out_ready = 1'b0;
        #3;
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00", {out_valid, busy});
        end
        n_cmp++;
        if (out_state !== 128'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h want 0", out_state);
        end
        #9 rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_widths();
        in_state = V_IN; in_bypass = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({busy, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL w1_accept: busy,out_valid got %b want 10", {busy, out_valid});
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== (k == 4) || busy !== 1'b1) begin
                n_err++;
                $display("FAIL w1_valid k=%0d: out_valid,busy got %b%b want %b1",
                         k, out_valid, busy, (k == 4));
            end
            n_cmp++;
            if (out_valid2 !== (k == 2)) begin
                n_err++;
                $display("FAIL w2_valid k=%0d: got %b want %b", k, out_valid2, (k == 2));
            end
            n_cmp++;
            if (out_valid4 !== (k == 1)) begin
                n_err++;
                $display("FAIL w4_valid k=%0d: got %b want %b", k, out_valid4, (k == 1));
            end
            if (k == 4) begin
                n_cmp++;
                if (out_state !== V_OUT) begin
                    n_err++;
                    $display("FAIL w1_data: got %h want %h", out_state, V_OUT);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (out_state2 !== V_OUT) begin
                    n_err++;
                    $display("FAIL w2_data: got %h want %h", out_state2, V_OUT);
                end
            end
            if (k == 1) begin
                n_cmp++;
                if (out_state4 !== V_OUT) begin
                    n_err++;
                    $display("FAIL w4_data: got %h want %h", out_state4, V_OUT);
                end
            end
        end
        tick();
        n_cmp++;
        if ({busy, out_valid, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL w1_idle: busy,out_valid,in_ready got %b want 001",
                     {busy, out_valid, in_ready});
        end
    endtask

    task automatic test_bypass();
        in_state = B_IN; in_bypass = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_bypass = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_state !== B_IN) begin
            n_err++;
            $display("FAIL bypass_out: valid %b data %h want 1 %h",
                     out_valid, out_state, B_IN);
        end
        tick();
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL bypass_drain: got %b want 00", {out_valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        in_state = V_IN; in_bypass = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_state !== V_OUT) begin
            n_err++;
            $display("FAIL bp_first: valid %b data %h want 1 %h",
                     out_valid, out_state, V_OUT);
        end
        in_state = W_IN; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_state !== V_OUT || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold k=%0d: valid %b ready %b data %h want 1 0 %h",
                         k, out_valid, in_ready, out_state, V_OUT);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b010) begin
            n_err++;
            $display("FAIL b2b_accept: valid,busy,ready got %b want 010",
                     {out_valid, busy, in_ready});
        end
        repeat (3) tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_early: got %b want 0", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_state !== W_OUT) begin
            n_err++;
            $display("FAIL b2b_data: valid %b data %h want 1 %h",
                     out_valid, out_state, W_OUT);
        end
        tick();
    endtask

    task automatic test_flush();
        logic seen;
        in_state = V_IN; in_bypass = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready_run: got %b want 0", in_ready);
        end
        tick();
        flush = 1'b0;
        #1;
        n_cmp++;
        if ({busy, out_valid, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL flush_idle: busy,valid,ready got %b want 001",
                     {busy, out_valid, in_ready});
        end
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen = seen | out_valid;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_valid: got %b want 0", seen);
        end
        flush = 1'b1; in_valid = 1'b1; in_state = B_IN;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready_idle: got %b want 0", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_accept: busy got %b want 0", busy);
        end
        in_state = W_IN; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_state !== W_OUT) begin
            n_err++;
            $display("FAIL flush_next: valid %b data %h want 1 %h",
                     out_valid, out_state, W_OUT);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        in_state = V_IN; in_bypass = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b000 || out_state !== 128'h0) begin
            n_err++;
            $display("FAIL rst_mid: valid,busy,ready %b data %h want 000 0",
                     {out_valid, busy, in_ready}, out_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_release: ready,busy got %b want 10", {in_ready, busy});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_widths();
        test_bypass();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
